// File: rtl/wb_select_stage_pkg.sv
// Shared encodings for the write-back source select and load size fields,
// used by both the decoder and the MEM/WB selection stage.
package wb_select_stage_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_LINK = 2'd2,
        WB_RSVD = 2'd3
    } wsel_e;

    typedef enum logic [1:0] {
        LD_B    = 2'd0,
        LD_H    = 2'd1,
        LD_W    = 2'd2,
        LD_RSVD = 2'd3
    } lsize_e;

endpackage

// File: rtl/wb_select_stage_load_align.sv
// Combinational sub-word load extraction: picks the addressed lane of the raw
// memory word, extends it to the datapath width and flags misaligned accesses.
module load_align
    import wb_select_stage_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OFS_W = 2
) (
    input  logic [WIDTH-1:0] di,
    input  logic [OFS_W-1:0] ofs,
    input  logic [1:0]       lsize,
    input  logic             lsign,
    output logic [WIDTH-1:0] data,
    output logic             misalign
);

    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] sh_h;
    logic [WIDTH-1:0] sh_w;
    logic [OFS_W-1:0] hlane;
    logic [OFS_W-1:0] wlane;

    // Lanes are selected by shifting the addressed lane down to bit 0; for
    // WIDTH=32 the word lane index is always 0, so a word load returns di.
    assign hlane = ofs >> 1;
    assign wlane = ofs >> 2;
    assign sh_b  = di >> {ofs, 3'b000};
    assign sh_h  = di >> {hlane, 4'b0000};
    assign sh_w  = di >> {wlane, 5'b00000};

    always_comb begin
        data     = '0;
        misalign = 1'b0;
        case (lsize_e'(lsize))
            LD_B: begin
                data      = (lsign && sh_b[7]) ? '1 : '0;
                data[7:0] = sh_b[7:0];
            end
            LD_H: begin
                data       = (lsign && sh_h[15]) ? '1 : '0;
                data[15:0] = sh_h[15:0];
                misalign   = ofs[0];
            end
            default: begin
                data       = (lsign && sh_w[31]) ? '1 : '0;
                data[31:0] = sh_w[31:0];
                misalign   = (ofs[1:0] != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/wb_select_stage.sv
// MEM/WB boundary: selects ALU result, aligned load data or link address and
// registers it with destination and effective write enable, under stall/flush.
module wb_select_stage
    import wb_select_stage_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int RN_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] di,
    input  logic [WIDTH-1:0] link,
    input  logic [1:0]       wsel,
    input  logic [1:0]       lsize,
    input  logic             lsign,
    input  logic [RN_W-1:0]  rn,
    input  logic             wreg,
    input  logic             stall,
    input  logic             flush,
    output logic             wb_valid,
    output logic [WIDTH-1:0] wb_data,
    output logic [RN_W-1:0]  wb_rn,
    output logic             wb_wreg,
    output logic             misalign
);

    localparam int OFS_W = $clog2(WIDTH / 8);

    logic [WIDTH-1:0] ld_data;
    logic             ld_mis;
    logic [WIDTH-1:0] sel_data;
    logic             eff_wreg;
    logic             eff_mis;

    load_align #(
        .WIDTH (WIDTH),
        .OFS_W (OFS_W)
    ) u_load_align (
        .di       (di),
        .ofs      (r[OFS_W-1:0]),
        .lsize    (lsize),
        .lsign    (lsign),
        .data     (ld_data),
        .misalign (ld_mis)
    );

    always_comb begin
        sel_data = r;
        case (wsel_e'(wsel))
            WB_MEM:  sel_data = ld_data;
            WB_LINK: sel_data = link;
            default: sel_data = r;
        endcase
    end

    assign eff_wreg = in_valid && wreg && (rn != '0);
    assign eff_mis  = in_valid && (wsel_e'(wsel) == WB_MEM) && ld_mis;

    // Flush kills the control bits only; data and destination keep their
    // last values since nothing downstream looks at them without wb_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_data  <= '0;
            wb_rn    <= '0;
            wb_wreg  <= 1'b0;
            misalign <= 1'b0;
        end else if (flush) begin
            wb_valid <= 1'b0;
            wb_wreg  <= 1'b0;
            misalign <= 1'b0;
        end else if (!stall) begin
            wb_valid <= in_valid;
            wb_data  <= sel_data;
            wb_rn    <= rn;
            wb_wreg  <= eff_wreg;
            misalign <= eff_mis;
        end
    end

endmodule
